// File: rtl/ne_dot_tree_seq_if.sv
// ne_dot_tree_seq_if
//   Bundles the job-control, product-stream, tree and result signals of the
//   NE dot-product tree sequencer.
//   slave  : the sequencer side (ne_dot_tree_seq).
//   master : the surrounding PE / environment that drives jobs and products,
//            models the reduction tree and consumes results.
//   Signals:
//     start, len            job start pulse and beat count
//     busy                  sequencer not idle
//     in_valid/in_ready     product-vector handshake, in_data = packed products
//     tree_in               registered tree input bus
//     tree_out0/tree_out1   tree sum and carry words
//     res_valid/res_ready   result handshake, res_data = signed dot product
//     sat_flag              accumulator clamped during the current job
interface ne_dot_tree_seq_if #(
    parameter int NUM_IN = 16,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
);
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic [NUM_IN*IN_W-1:0]   tree_in;
    logic [IN_W-1:0]          tree_out0;
    logic [IN_W-1:0]          tree_out1;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic                     sat_flag;

    modport slave (
        input  start, len, in_valid, in_data, tree_out0, tree_out1, res_ready,
        output busy, in_ready, tree_in, res_valid, res_data, sat_flag
    );

    modport master (
        output start, len, in_valid, in_data, tree_out0, tree_out1, res_ready,
        input  busy, in_ready, tree_in, res_valid, res_data, sat_flag
    );
endinterface

// File: rtl/ne_dot_tree_seq.sv
// ne_dot_tree_seq
//   Sequencer for the 16-input carry-save reduction tree of the NE
//   dot-product PE. A job of len beats is accepted over a valid/ready
//   stream; each beat is registered onto the tree inputs, the tree's two
//   output words are added one cycle later and accumulated, and the final
//   sum is returned over a valid/ready result port.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   ne_dot_tree_seq_if.slave (start/len/busy, in_* stream,
//           tree_in/tree_out0/tree_out1, res_* result, sat_flag)
//   Build option:
//     NE_DOT_SAT_EN  defined   -> signed-saturating accumulation, sat_flag live
//                    undefined -> accumulation wraps mod 2^ACC_W, sat_flag = 0
module ne_dot_tree_seq #(
    parameter int NUM_IN = 16,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    ne_dot_tree_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic                     r_v1;
    logic [NUM_IN*IN_W-1:0]   r_tree_in;
    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_res;

    logic                     w_in_ready;
    logic                     w_accept;
    logic [LEN_W-1:0]         w_cnt_nxt;
    logic                     w_last;
    logic signed [IN_W-1:0]   w_psum;
    logic signed [ACC_W-1:0]  w_psum_ext;
    logic signed [ACC_W-1:0]  w_acc_nxt;

    assign w_in_ready = (r_state == S_RUN) && (r_cnt < r_len);
    assign w_accept   = w_in_ready && bus.in_valid;
    // r_cnt < r_len <= 2^LEN_W-1, so the increment never overflows
    assign w_cnt_nxt  = r_cnt + LEN_W'(1);
    assign w_last     = (w_cnt_nxt == r_len);

    // Carry-save resolve: sum + carry, truncated to IN_W, then sign-extended
    assign w_psum     = bus.tree_out0 + bus.tree_out1;
    assign w_psum_ext = ACC_W'(w_psum);

`ifdef NE_DOT_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                     r_sat;
    logic signed [ACC_W:0]    w_sum_wide;
    logic                     w_clamp;

    // One guard bit: overflow shows as the top two bits disagreeing
    always_comb begin
        w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_psum_ext);
        w_clamp    = 1'b0;
        w_acc_nxt  = w_sum_wide[ACC_W-1:0];
        if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
            w_clamp   = 1'b1;
            w_acc_nxt = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign bus.sat_flag = r_sat;
`else
    assign w_acc_nxt    = r_acc + w_psum_ext;
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_v1      <= 1'b0;
            r_tree_in <= '0;
            r_acc     <= '0;
            r_res     <= '0;
`ifdef NE_DOT_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_tree_in <= bus.in_data;
                r_cnt     <= w_cnt_nxt;
            end
            if (r_v1) begin
                r_acc <= w_acc_nxt;
`ifdef NE_DOT_SAT_EN
                if (w_clamp) r_sat <= 1'b1;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_len <= bus.len;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_res <= '0;
`ifdef NE_DOT_SAT_EN
                        r_sat <= 1'b0;
`endif
                        r_state <= (bus.len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // v1 clear means the last beat's partial sum is already in r_acc
                    if (!r_v1) begin
                        r_res   <= r_acc;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.tree_in   = r_tree_in;
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_data  = r_res;

endmodule
